gridworld_env: RTL and testbench

Sequential environment responder for the Q-learning gridworld. It holds the agent's position on the 5x5 grid. Each accepted action is answered with next state, reward and terminal flags. It also counts steps and episodes and restarts episodes on its own, so the agent side can act as a pure initiator over a valid/ready handshake.

---
 rtl/rl_pkg.sv | 32 +++
 rtl/gridworld_step.sv | 90 +++++++++
 rtl/gridworld_env.sv | 155 +++++++++++++++
 tb/tb_gridworld_env.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rl_pkg.sv
// Shared constants and types for the Q-learning gridworld environment:
// action encodings, grid landmarks, hole map, rewards and the FSM state enum.
package rl_pkg;

    localparam int STATE_W = 6;

    localparam logic [3:0] ACT_UP    = 4'b0001;
    localparam logic [3:0] ACT_DOWN  = 4'b0010;
    localparam logic [3:0] ACT_LEFT  = 4'b0100;
    localparam logic [3:0] ACT_RIGHT = 4'b1000;

    localparam logic [STATE_W-1:0] START_STATE = 6'd1;
    localparam logic [STATE_W-1:0] GOAL_STATE  = 6'd25;

    // Bit (s-1) set when state s is a hole: 5, 7, 8, 14, 17, 19, 20, 22.
    localparam logic [24:0] HOLE_MASK = (25'd1 << 4)  | (25'd1 << 6)  | (25'd1 << 7)  |
                                        (25'd1 << 13) | (25'd1 << 16) | (25'd1 << 18) |
                                        (25'd1 << 19) | (25'd1 << 21);

    localparam logic signed [15:0] R_GOAL = 16'sd100;
    localparam logic signed [15:0] R_HOLE = -16'sd100;
    localparam logic signed [15:0] R_BUMP = -16'sd5;
    localparam logic signed [15:0] R_STEP = -16'sd1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_ACT,
        ST_RESPOND,
        ST_EXHAUSTED
    } env_state_e;

endpackage

// File: rtl/gridworld_step.sv
// Combinational single-step transition of the 5x5 gridworld: applies one
// action to a position and classifies the landing cell.
module gridworld_step
    import rl_pkg::*;
(
    input  logic [STATE_W-1:0]   pos,
    input  logic [3:0]           action,
    output logic [STATE_W-1:0]   next_state,
    output logic signed [15:0]   reward,
    output logic                 is_goal,
    output logic                 is_hole,
    output logic                 is_bump
);

    logic [4:0]  idx;
    logic [2:0]  row;
    logic [4:0]  col;
    logic [24:0] hole_hit;

    assign idx = 5'(pos - STATE_W'(1));

    // Row/column from the 0-based index without a divider.
    always_comb begin
        if (idx >= 5'd20) begin
            row = 3'd4;
            col = idx - 5'd20;
        end else if (idx >= 5'd15) begin
            row = 3'd3;
            col = idx - 5'd15;
        end else if (idx >= 5'd10) begin
            row = 3'd2;
            col = idx - 5'd10;
        end else if (idx >= 5'd5) begin
            row = 3'd1;
            col = idx - 5'd5;
        end else begin
            row = 3'd0;
            col = idx;
        end
    end

    always_comb begin
        next_state = pos;
        is_bump    = 1'b1;
        case (action)
            ACT_UP: begin
                if (row != 3'd0) begin
                    next_state = pos - STATE_W'(5);
                    is_bump    = 1'b0;
                end
            end
            ACT_DOWN: begin
                if (row != 3'd4) begin
                    next_state = pos + STATE_W'(5);
                    is_bump    = 1'b0;
                end
            end
            ACT_LEFT: begin
                if (col != 5'd0) begin
                    next_state = pos - STATE_W'(1);
                    is_bump    = 1'b0;
                end
            end
            ACT_RIGHT: begin
                if (col != 5'd4) begin
                    next_state = pos + STATE_W'(1);
                    is_bump    = 1'b0;
                end
            end
            default: ;
        endcase
    end

    generate
        for (genvar gi = 0; gi < 25; gi++) begin : g_hole
            assign hole_hit[gi] = HOLE_MASK[gi] && (next_state == STATE_W'(gi + 1));
        end
    endgenerate

    assign is_goal = (next_state == GOAL_STATE);
    assign is_hole = |hole_hit;

    always_comb begin
        if (is_goal)      reward = R_GOAL;
        else if (is_hole) reward = R_HOLE;
        else if (is_bump) reward = R_BUMP;
        else              reward = R_STEP;
    end

endmodule

// File: rtl/gridworld_env.sv
// Gridworld environment responder: accepts agent actions over valid/ready,
// answers each with next state/reward/flags, and sequences episodes itself.
// Optional trace port enabled by defining GRIDWORLD_TRACE_EN.
module gridworld_env
    import rl_pkg::*;
#(
    parameter int MAX_STEPS    = 15,
    parameter int MAX_EPISODES = 300
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 act_valid,
    output logic                 act_ready,
    input  logic [3:0]           action,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [STATE_W-1:0]   next_state,
    output logic signed [15:0]   next_reward,
    output logic                 ep_end,
    output logic                 goal_hit,
    output logic [9:0]           episode,
    output logic [3:0]           step_cnt,
    output logic                 exhausted
`ifdef GRIDWORLD_TRACE_EN
    ,
    output logic                 trace_valid,
    output logic [31:0]          trace_word
`endif
);

    localparam logic [3:0] STEP_LIMIT = 4'(MAX_STEPS);
    localparam logic [9:0] EP_LIMIT   = 10'(MAX_EPISODES);

    env_state_e          state_reg, state_next;
    logic [STATE_W-1:0]  pos_reg, pos_next;
    logic [9:0]          episode_reg, episode_next;
    logic [3:0]          step_cnt_reg, step_cnt_next;
    logic [STATE_W-1:0]  ns_reg, ns_next;
    logic signed [15:0]  reward_reg, reward_next;
    logic                ep_end_reg, ep_end_next;
    logic                goal_hit_reg, goal_hit_next;

    logic [STATE_W-1:0]  step_ns;
    logic signed [15:0]  step_reward;
    logic                step_goal;
    logic                step_hole;
    logic                step_bump;
    logic [3:0]          step_inc;

    gridworld_step u_step (
        .pos        (pos_reg),
        .action     (action),
        .next_state (step_ns),
        .reward     (step_reward),
        .is_goal    (step_goal),
        .is_hole    (step_hole),
        .is_bump    (step_bump)
    );

    assign step_inc = step_cnt_reg + 4'd1;

    always_comb begin
        state_next    = state_reg;
        pos_next      = pos_reg;
        episode_next  = episode_reg;
        step_cnt_next = step_cnt_reg;
        ns_next       = ns_reg;
        reward_next   = reward_reg;
        ep_end_next   = ep_end_reg;
        goal_hit_next = goal_hit_reg;
        case (state_reg)
            ST_IDLE, ST_EXHAUSTED: begin
                if (start) begin
                    state_next    = ST_WAIT_ACT;
                    episode_next  = 10'd1;
                    step_cnt_next = 4'd0;
                    pos_next      = START_STATE;
                end
            end
            ST_WAIT_ACT: begin
                if (act_valid) begin
                    ns_next       = step_bump ? pos_reg : step_ns;
                    reward_next   = step_reward;
                    goal_hit_next = step_goal;
                    // Goal/hole take precedence for reward; timeout only forces the end flag.
                    ep_end_next   = step_goal || step_hole || (step_inc == STEP_LIMIT);
                    step_cnt_next = step_inc;
                    state_next    = ST_RESPOND;
                end
            end
            ST_RESPOND: begin
                if (resp_ready) begin
                    if (!ep_end_reg) begin
                        pos_next   = ns_reg;
                        state_next = ST_WAIT_ACT;
                    end else if (episode_reg < EP_LIMIT) begin
                        episode_next  = episode_reg + 10'd1;
                        step_cnt_next = 4'd0;
                        pos_next      = START_STATE;
                        state_next    = ST_WAIT_ACT;
                    end else begin
                        state_next = ST_EXHAUSTED;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            pos_reg      <= START_STATE;
            episode_reg  <= 10'd0;
            step_cnt_reg <= 4'd0;
            ns_reg       <= START_STATE;
            reward_reg   <= 16'sd0;
            ep_end_reg   <= 1'b0;
            goal_hit_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            pos_reg      <= pos_next;
            episode_reg  <= episode_next;
            step_cnt_reg <= step_cnt_next;
            ns_reg       <= ns_next;
            reward_reg   <= reward_next;
            ep_end_reg   <= ep_end_next;
            goal_hit_reg <= goal_hit_next;
        end
    end

    assign act_ready   = (state_reg == ST_WAIT_ACT);
    assign resp_valid  = (state_reg == ST_RESPOND);
    assign exhausted   = (state_reg == ST_EXHAUSTED);
    assign next_state  = ns_reg;
    assign next_reward = reward_reg;
    assign ep_end      = ep_end_reg;
    assign goal_hit    = goal_hit_reg;
    assign episode     = episode_reg;
    assign step_cnt    = step_cnt_reg;

`ifdef GRIDWORLD_TRACE_EN
    logic trace_valid_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) trace_valid_reg <= 1'b0;
        else        trace_valid_reg <= (state_reg == ST_WAIT_ACT) && act_valid;
    end

    assign trace_valid = trace_valid_reg;
    assign trace_word  = {episode_reg, step_cnt_reg, ns_reg, reward_reg[11:0]};
`endif

endmodule

// File: tb/tb_gridworld_env.sv
// Randomized self-checking bench for gridworld_env against a grid-level model.
module tb_gridworld_env;

    localparam int MAX_STEPS    = 15;
    localparam int MAX_EPISODES = 300;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        act_valid;
    logic        act_ready;
    logic [3:0]  action;
    logic        resp_valid;
    logic        resp_ready;
    logic [5:0]  next_state;
    logic [15:0] next_reward;
    logic        ep_end;
    logic        goal_hit;
    logic [9:0]  episode;
    logic [3:0]  step_cnt;
    logic        exhausted;

    gridworld_env #(.MAX_STEPS(MAX_STEPS), .MAX_EPISODES(MAX_EPISODES)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .act_valid   (act_valid),
        .act_ready   (act_ready),
        .action      (action),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .next_state  (next_state),
        .next_reward (next_reward),
        .ep_end      (ep_end),
        .goal_hit    (goal_hit),
        .episode     (episode),
        .step_cnt    (step_cnt),
        .exhausted   (exhausted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: phase 0 idle, 1 waiting for action, 2 responding, 3 exhausted.
    int m_phase = 0;
    int m_pos   = 1;
    int m_ep    = 0;
    int m_cnt   = 0;
    int e_ns    = 1;
    int e_rw    = 0;
    int e_end   = 0;
    int e_goal  = 0;

    int holes[8] = '{5, 7, 8, 14, 17, 19, 20, 22};

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic bit is_hole(input int s);
        foreach (holes[i]) if (holes[i] == s) return 1'b1;
        return 1'b0;
    endfunction

    function automatic void grid_move(input int pos, input logic [3:0] a,
                                      output int ns, output int rw);
        int r = (pos - 1) / 5;
        int c = (pos - 1) % 5;
        bit bump = 1'b1;
        ns = pos;
        case (a)
            4'b0001: if (r > 0) begin ns = pos - 5; bump = 1'b0; end
            4'b0010: if (r < 4) begin ns = pos + 5; bump = 1'b0; end
            4'b0100: if (c > 0) begin ns = pos - 1; bump = 1'b0; end
            4'b1000: if (c < 4) begin ns = pos + 1; bump = 1'b0; end
            default: ;
        endcase
        if (ns == 25)         rw = 100;
        else if (is_hole(ns)) rw = -100;
        else if (bump)        rw = -5;
        else                  rw = -1;
    endfunction

    function automatic void model_reset();
        m_phase = 0; m_pos = 1; m_ep = 0; m_cnt = 0;
        e_ns = 1; e_rw = 0; e_end = 0; e_goal = 0;
    endfunction

    function automatic void model_accept(input logic [3:0] a);
        int ns, rw;
        grid_move(m_pos, a, ns, rw);
        m_cnt++;
        e_ns   = ns;
        e_rw   = rw;
        e_goal = (ns == 25);
        e_end  = (ns == 25 || is_hole(ns) || m_cnt == MAX_STEPS);
        m_phase = 2;
    endfunction

    function automatic void model_consume();
        if (!e_end) begin
            m_pos = e_ns; m_phase = 1;
        end else if (m_ep < MAX_EPISODES) begin
            m_ep++; m_cnt = 0; m_pos = 1; m_phase = 1;
        end else begin
            m_phase = 3;
        end
    endfunction

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        chk("act_ready",   act_ready,  m_phase == 1);
        chk("resp_valid",  resp_valid, m_phase == 2);
        chk("exhausted",   exhausted,  m_phase == 3);
        chk("episode",     episode,    m_ep);
        chk("step_cnt",    step_cnt,   m_cnt);
        chk("next_state",  next_state, e_ns);
        chk("next_reward", $signed(next_reward), e_rw);
        chk("ep_end",      ep_end,     e_end);
        chk("goal_hit",    goal_hit,   e_goal);
    end

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        if (m_phase == 0 || m_phase == 3) begin
            m_phase = 1; m_ep = 1; m_cnt = 0; m_pos = 1;
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic gap(input int n);
        for (int i = 0; i < n; i++) begin
            resp_ready = 1'($urandom_range(0, 1));
            if (m_phase == 1 && $urandom_range(0, 3) == 0) start = 1'b1;
            @(negedge clk);
            resp_ready = 1'b0;
            start      = 1'b0;
        end
    endtask

    // One action/response transaction; optional literal check of the response.
    task automatic do_step(input logic [3:0] a, input int delay, input bit lit,
                           input int ens, input int erw, input int eend);
        act_valid = 1'b1;
        action    = a;
        @(posedge clk);
        model_accept(a);
        @(negedge clk);
        act_valid = 1'b0;
        action    = 4'($urandom);
        $display("step ep=%0d cnt=%0d act=%b -> ns=%0d rw=%0d end=%0d goal=%0d",
                 episode, step_cnt, a, next_state, $signed(next_reward), ep_end, goal_hit);
        if (lit) begin
            chk("lit_next_state",  next_state, ens);
            chk("lit_next_reward", $signed(next_reward), erw);
            chk("lit_ep_end",      ep_end, eend);
        end
        for (int i = 0; i < delay; i++) begin
            act_valid = 1'($urandom_range(0, 1));
            start     = ($urandom_range(0, 3) == 0);
            @(negedge clk);
            act_valid = 1'b0;
            start     = 1'b0;
        end
        resp_ready = 1'b1;
        @(posedge clk);
        model_consume();
        @(negedge clk);
        resp_ready = 1'b0;
    endtask

    function automatic logic [3:0] rand_action();
        case ($urandom_range(0, 4))
            0: return 4'b0001;
            1: return 4'b0010;
            2: return 4'b0100;
            3: return 4'b1000;
            default: return 4'($urandom);
        endcase
    endfunction

    initial begin
        rst_n = 1'b1; start = 1'b0; act_valid = 1'b0; action = 4'd0; resp_ready = 1'b0;
        #1 rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        chk("rst_next_state", next_state, 1);
        chk("rst_act_ready",  act_ready, 0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        pulse_start();
        chk("start_episode", episode, 1);

        // Episode 1: basic moves, bumps, invalid action, then hole at 17.
        do_step(4'b1000, 0, 1, 2, -1, 0);
        do_step(4'b0100, 1, 1, 1, -1, 0);
        do_step(4'b0001, 0, 1, 1, -5, 0);
        do_step(4'b0011, 2, 1, 1, -5, 0);
        do_step(4'b0010, 0, 1, 6, -1, 0);
        do_step(4'b0010, 0, 1, 11, -1, 0);
        do_step(4'b0010, 0, 1, 16, -1, 0);
        do_step(4'b1000, 0, 1, 17, -100, 1);
        chk("ep2_episode", episode, 2);

        // Episode 2: path into hole 20.
        do_step(4'b1000, 0, 1, 2, -1, 0);
        do_step(4'b1000, 0, 1, 3, -1, 0);
        do_step(4'b1000, 0, 1, 4, -1, 0);
        do_step(4'b0010, 0, 1, 9, -1, 0);
        do_step(4'b1000, 0, 1, 10, -1, 0);
        do_step(4'b0010, 0, 1, 15, -1, 0);
        do_step(4'b0010, 0, 1, 20, -100, 1);

        // Episode 3: goal via 18, 23, 24.
        do_step(4'b0010, 0, 1, 6, -1, 0);
        do_step(4'b0010, 0, 1, 11, -1, 0);
        do_step(4'b1000, 0, 1, 12, -1, 0);
        do_step(4'b1000, 0, 1, 13, -1, 0);
        do_step(4'b0010, 0, 1, 18, -1, 0);
        do_step(4'b0010, 0, 1, 23, -1, 0);
        do_step(4'b1000, 0, 1, 24, -1, 0);
        do_step(4'b1000, 0, 1, 25, 100, 1);
        chk("ep4_episode", episode, 4);

        // Episode 4: timeout after 15 wall bumps.
        for (int i = 0; i < MAX_STEPS; i++)
            do_step(4'b0100, 0, 1, 1, -5, (i == MAX_STEPS - 1) ? 1 : 0);
        chk("timeout_step_cnt", step_cnt, 0);

        // Episode 5: goal reached exactly on the last allowed step.
        for (int i = 0; i < 7; i++) do_step(4'b0100, 0, 0, 0, 0, 0);
        do_step(4'b0010, 0, 0, 0, 0, 0);
        do_step(4'b0010, 0, 0, 0, 0, 0);
        do_step(4'b1000, 0, 0, 0, 0, 0);
        do_step(4'b1000, 0, 0, 0, 0, 0);
        do_step(4'b0010, 0, 0, 0, 0, 0);
        do_step(4'b0010, 0, 0, 0, 0, 0);
        do_step(4'b1000, 0, 0, 0, 0, 0);
        do_step(4'b1000, 0, 1, 25, 100, 1);

        // Random play until the episode budget is used up.
        while (m_phase == 1) begin
            gap($urandom_range(0, 1));
            do_step(rand_action(), $urandom_range(0, 2), 0, 0, 0, 0);
        end
        chk("lit_exhausted", exhausted, 1);
        chk("lit_exh_ready", act_ready, 0);
        chk("lit_exh_episode", episode, MAX_EPISODES);

        act_valid = 1'b1; action = 4'b1000;
        repeat (3) @(negedge clk);
        act_valid = 1'b0;
        pulse_start();
        chk("restart_episode", episode, 1);

        // Reset while a response is pending.
        act_valid = 1'b1; action = 4'b0010;
        @(posedge clk);
        model_accept(4'b0010);
        @(negedge clk);
        act_valid = 1'b0;
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst_resp_valid",  resp_valid, 0);
        chk("rst_act_ready2",  act_ready, 0);
        chk("rst_next_state2", next_state, 1);
        chk("rst_reward2",     $signed(next_reward), 0);
        chk("rst_episode2",    episode, 0);
        chk("rst_step_cnt2",   step_cnt, 0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        pulse_start();
        do_step(4'b1000, 0, 1, 2, -1, 0);
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
